// File: rtl/ifetch_ctrl_if.sv
// rtl/ifetch_ctrl_if.sv - fetch-side and memory-side signals of the instruction-fetch controller.
interface ifetch_ctrl_if;
   logic         pc_req;
   logic [31:0]  pc_addr;
   logic         flush;
   logic [31:0]  instruction;
   logic         inst_valid;
   logic         stall;
   logic [31:0]  mem_address;
   logic [127:0] mem_dataline;

   modport master (
      input  pc_req, pc_addr, flush, mem_dataline,
      output instruction, inst_valid, stall, mem_address
   );

   modport slave (
      output pc_req, pc_addr, flush, mem_dataline,
      input  instruction, inst_valid, stall, mem_address
   );
endinterface

// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - line-buffered instruction fetch with multi-cycle memory fill.
// Optional next-line prefetch buffer is compiled in with IFETCH_PREFETCH_EN.
module ifetch_ctrl #(
   parameter int MEM_LATENCY = 6
) (
   input logic           clk,
   input logic           reset,
   ifetch_ctrl_if.master bus
);
   localparam int            CW  = $clog2(MEM_LATENCY + 1);
   localparam logic [CW-1:0] LAT = CW'(MEM_LATENCY);

   typedef enum logic [1:0] {
      IDLE,
      FILL
`ifdef IFETCH_PREFETCH_EN
      , PREFETCH
`endif
   } state_t;

   state_t        state;
   logic [127:0]  line;
   logic [27:0]   line_tag;
   logic          line_valid;
   logic [27:0]   fill_tag;
   logic [CW-1:0] fill_cnt;

   logic [27:0]   req_tag;
   logic          hit;
   logic          demand_miss;
   logic          vld;
   logic [31:0]   word;
   logic          unused_addr_bits;

`ifdef IFETCH_PREFETCH_EN
   logic [127:0]  pf_line;
   logic [27:0]   pf_tag;
   logic          pf_valid;
   logic [27:0]   next_tag;

   assign next_tag = line_tag + 28'd1;
`endif

   assign req_tag          = bus.pc_addr[31:4];
   assign unused_addr_bits = ^bus.pc_addr[1:0];
   assign hit              = line_valid && (line_tag == req_tag);
   assign demand_miss      = bus.pc_req && !hit;
   assign word             = line[{bus.pc_addr[3:2], 5'd0} +: 32];

   // Outputs are forced to their reset values while reset is held, even though they are combinational.
   assign vld             = !reset && !bus.flush && bus.pc_req && hit;
   assign bus.inst_valid  = vld;
   assign bus.stall       = !reset && bus.pc_req && !(hit && !bus.flush);
   assign bus.instruction = vld ? word : 32'd0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         line            <= '0;
         line_tag        <= '0;
         line_valid      <= 1'b0;
         fill_tag        <= '0;
         fill_cnt        <= '0;
         bus.mem_address <= '0;
`ifdef IFETCH_PREFETCH_EN
         pf_line         <= '0;
         pf_tag          <= '0;
         pf_valid        <= 1'b0;
`endif
      end else if (bus.flush) begin
         state      <= IDLE;
         line_valid <= 1'b0;
         fill_cnt   <= '0;
`ifdef IFETCH_PREFETCH_EN
         pf_valid   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (demand_miss) begin
`ifdef IFETCH_PREFETCH_EN
                  if (pf_valid && pf_tag == req_tag) begin
                     line       <= pf_line;
                     line_tag   <= pf_tag;
                     line_valid <= 1'b1;
                     pf_valid   <= 1'b0;
                  end else
`endif
                  begin
                     bus.mem_address <= {req_tag, 4'd0};
                     fill_tag        <= req_tag;
                     fill_cnt        <= '0;
                     state           <= FILL;
                  end
               end
`ifdef IFETCH_PREFETCH_EN
               else if (line_valid && !pf_valid && pf_tag != next_tag) begin
                  bus.mem_address <= {next_tag, 4'd0};
                  fill_tag        <= next_tag;
                  fill_cnt        <= '0;
                  state           <= PREFETCH;
               end
`endif
            end
            FILL: begin
               if (fill_cnt == LAT) begin
                  line       <= bus.mem_dataline;
                  line_tag   <= fill_tag;
                  line_valid <= 1'b1;
                  state      <= IDLE;
               end else begin
                  fill_cnt <= fill_cnt + CW'(1);
               end
            end
`ifdef IFETCH_PREFETCH_EN
            PREFETCH: begin
               // A demand for the in-flight line keeps the running count; any other demand restarts.
               if (demand_miss && req_tag != fill_tag) begin
                  bus.mem_address <= {req_tag, 4'd0};
                  fill_tag        <= req_tag;
                  fill_cnt        <= '0;
                  state           <= FILL;
               end else if (fill_cnt == LAT) begin
                  if (demand_miss) begin
                     line       <= bus.mem_dataline;
                     line_tag   <= fill_tag;
                     line_valid <= 1'b1;
                  end else begin
                     pf_line  <= bus.mem_dataline;
                     pf_tag   <= fill_tag;
                     pf_valid <= 1'b1;
                  end
                  state <= IDLE;
               end else begin
                  fill_cnt <= fill_cnt + CW'(1);
                  if (demand_miss) state <= FILL;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end
endmodule
